// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: request/response channels of both requesters plus the ALU hookup
//   r0_*/r1_*  : valid/ready request (op, in1, in2) and valid/ready response (data, err)
//   alu_*      : operands toward the external ALU and its combinational result
//   busy       : arbiter is serving an operation
//   slave      : arbiter side; master: requester/ALU side
interface alu_share_arbiter_if #(
   parameter int WIDTH = 32,
   parameter int OPW   = 6
);
   logic             r0_valid, r0_ready, r0_rsp_valid, r0_rsp_ready, r0_rsp_err;
   logic [OPW-1:0]   r0_op;
   logic [WIDTH-1:0] r0_in1, r0_in2, r0_rsp_data;
   logic             r1_valid, r1_ready, r1_rsp_valid, r1_rsp_ready, r1_rsp_err;
   logic [OPW-1:0]   r1_op;
   logic [WIDTH-1:0] r1_in1, r1_in2, r1_rsp_data;
   logic [OPW-1:0]   alu_op;
   logic [WIDTH-1:0] alu_in1, alu_in2, alu_out;
   logic             busy;
   modport slave (
      input  r0_valid, r0_op, r0_in1, r0_in2, r0_rsp_ready,
      input  r1_valid, r1_op, r1_in1, r1_in2, r1_rsp_ready,
      input  alu_out,
      output r0_ready, r0_rsp_valid, r0_rsp_data, r0_rsp_err,
      output r1_ready, r1_rsp_valid, r1_rsp_data, r1_rsp_err,
      output alu_op, alu_in1, alu_in2, busy
   );
   modport master (
      output r0_valid, r0_op, r0_in1, r0_in2, r0_rsp_ready,
      output r1_valid, r1_op, r1_in1, r1_in2, r1_rsp_ready,
      output alu_out,
      input  r0_ready, r0_rsp_valid, r0_rsp_data, r0_rsp_err,
      input  r1_ready, r1_rsp_valid, r1_rsp_data, r1_rsp_err,
      input  alu_op, alu_in1, alu_in2, busy
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one external combinational ALU between two requesters
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : slave side of alu_share_arbiter_if (two request/response channels, ALU hookup, busy)
module alu_share_arbiter #(
   parameter int WIDTH = 32,
   parameter int OPW   = 6
) (
   input  logic               clk,
   input  logic               rst,
   alu_share_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t           state_q, state_d;
   logic             owner_q, owner_d, last_q, last_d, err_q, err_d;
   logic [OPW-1:0]   op_q, op_d, acc_op;
   logic [WIDTH-1:0] in1_q, in1_d, in2_q, in2_d, res_q, res_d;
   logic             win, rdy0, rdy1, acc_legal, rsp_ack, rv0, rv1;
   // on a tie the requester that was not granted last wins
   assign win       = (bus.r0_valid && bus.r1_valid) ? !last_q : bus.r1_valid;
   assign rdy0      = state_q == IDLE && !rst && !win && bus.r0_valid;
   assign rdy1      = state_q == IDLE && !rst && win && bus.r1_valid;
   assign acc_op    = win ? bus.r1_op : bus.r0_op;
   // legal opcodes: the whole 01xxx block plus 11000 and 11101
   assign acc_legal = acc_op[4:3] == 2'b01 || acc_op[4:0] == 5'b11000 || acc_op[4:0] == 5'b11101;
   assign rsp_ack   = owner_q ? bus.r1_rsp_ready : bus.r0_rsp_ready;
   assign rv0       = state_q == RESP && !owner_q;
   assign rv1       = state_q == RESP && owner_q;
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      err_d   = err_q;
      op_d    = op_q;
      in1_d   = in1_q;
      in2_d   = in2_q;
      res_d   = res_q;
      case (state_q)
         IDLE: if (rdy0 || rdy1) begin
            op_d    = acc_op;
            in1_d   = win ? bus.r1_in1 : bus.r0_in1;
            in2_d   = win ? bus.r1_in2 : bus.r0_in2;
            owner_d = win;
            last_d  = win;
            err_d   = !acc_legal;
            state_d = EXEC;
         end
         EXEC: begin
            // illegal ops never latch whatever the ALU produces
            res_d   = err_q ? '0 : bus.alu_out;
            state_d = RESP;
         end
         RESP: state_d = rsp_ack ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         err_q   <= 1'b0;
         op_q    <= '0;
         in1_q   <= '0;
         in2_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         err_q   <= err_d;
         op_q    <= op_d;
         in1_q   <= in1_d;
         in2_q   <= in2_d;
         res_q   <= res_d;
      end
   end
   assign bus.r0_ready     = rdy0;
   assign bus.r1_ready     = rdy1;
   assign bus.r0_rsp_valid = rv0;
   assign bus.r1_rsp_valid = rv1;
   // the non-owner sees zeros so a result never leaks onto the wrong channel
   assign bus.r0_rsp_data  = rv0 ? res_q : '0;
   assign bus.r1_rsp_data  = rv1 ? res_q : '0;
   assign bus.r0_rsp_err   = rv0 && err_q;
   assign bus.r1_rsp_err   = rv1 && err_q;
   assign bus.alu_op       = op_q;
   assign bus.alu_in1      = in1_q;
   assign bus.alu_in2      = in2_q;
   assign bus.busy         = state_q != IDLE;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: scoreboard bench with a cycle-level reference model of the shared ALU arbiter
module tb_alu_share_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   alu_share_arbiter_if #(.WIDTH(32), .OPW(6)) bus();
   alu_share_arbiter #(.WIDTH(32), .OPW(6)) dut (.clk(clk), .rst(rst), .bus(bus));
   typedef struct {
      bit          who;
      logic [31:0] data;
      bit          err;
   } entry_t;
   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   entry_t sb[$];
   bit grants[$];
   int gcyc[$];
   bit m_busy = 1'b0;
   bit m_last = 1'b1;
   bit m_owner = 1'b0;
   int m_age = 0;
   logic [5:0] m_op;
   logic [31:0] m_a, m_b;
   function automatic logic [31:0] alu_f(logic [5:0] op, logic [31:0] a, logic [31:0] b);
      case (op[4:0])
         5'b01000: return a + b;
         5'b11000: return a - b;
         5'b01001: return a << b[4:0];
         5'b01010: return {31'd0, $signed(a) < $signed(b)};
         5'b01011: return {31'd0, a < b};
         5'b01100: return a ^ b;
         5'b01101: return a >> b[4:0];
         5'b11101: return $signed(a) >>> b[4:0];
         5'b01110: return a | b;
         5'b01111: return a & b;
         default:  return 32'hDEAD_BEEF;
      endcase
   endfunction
   function automatic bit legal(logic [5:0] op);
      return op[4:0] inside {5'b01000, 5'b11000, 5'b01001, 5'b01010, 5'b01011,
                             5'b01100, 5'b01101, 5'b11101, 5'b01110, 5'b01111};
   endfunction
   always_comb bus.alu_out = alu_f(bus.alu_op, bus.alu_in1, bus.alu_in2);
   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask
   // reference model: evaluated once per cycle on the falling edge
   always @(negedge clk) begin
      bit v0, v1, want, e0, e1, ack, x0, x1, n;
      entry_t ex;
      cyc++;
      v0 = bus.r0_valid;
      v1 = bus.r1_valid;
      want = (v0 && v1) ? !m_last : v1;
      e0 = !rst && !m_busy && v0 && !want;
      e1 = !rst && !m_busy && v1 && want;
      chk("r0_ready", bus.r0_ready, e0);
      chk("r1_ready", bus.r1_ready, e1);
      chk("busy", bus.busy, m_busy);
      x0 = m_busy && m_age >= 2 && !m_owner;
      x1 = m_busy && m_age >= 2 && m_owner;
      chk("r0_rsp_valid", bus.r0_rsp_valid, x0);
      chk("r1_rsp_valid", bus.r1_rsp_valid, x1);
      if (bus.r0_valid && bus.r0_ready) begin grants.push_back(1'b0); gcyc.push_back(cyc); end
      if (bus.r1_valid && bus.r1_ready) begin grants.push_back(1'b1); gcyc.push_back(cyc); end
      if (m_busy) begin
         chk("alu_op", bus.alu_op, m_op);
         chk("alu_in1", bus.alu_in1, m_a);
         chk("alu_in2", bus.alu_in2, m_b);
      end
      if (bus.r0_rsp_valid || bus.r1_rsp_valid) begin
         if (sb.size() == 0) chk("sb_empty", 1, 0);
         else begin
            chk("rsp_owner", bus.r1_rsp_valid, sb[0].who);
            chk("rsp_data", sb[0].who ? bus.r1_rsp_data : bus.r0_rsp_data, sb[0].data);
            chk("rsp_err", sb[0].who ? bus.r1_rsp_err : bus.r0_rsp_err, sb[0].err);
         end
      end
      if (!x0) chk("r0_idle_data", {bus.r0_rsp_err, bus.r0_rsp_data}, 0);
      if (!x1) chk("r1_idle_data", {bus.r1_rsp_err, bus.r1_rsp_data}, 0);
      ack = m_owner ? bus.r1_rsp_ready : bus.r0_rsp_ready;
      if (rst) begin
         m_busy = 0;
         m_last = 1;
         sb.delete();
      end else if (e0 || e1) begin
         n = e1;
         m_busy = 1;
         m_age = 1;
         m_owner = n;
         m_last = n;
         m_op = n ? bus.r1_op : bus.r0_op;
         m_a = n ? bus.r1_in1 : bus.r0_in1;
         m_b = n ? bus.r1_in2 : bus.r0_in2;
         ex.who = n;
         ex.err = !legal(m_op);
         ex.data = ex.err ? 32'd0 : alu_f(m_op, m_a, m_b);
         sb.push_back(ex);
      end else if (m_busy) begin
         if (m_age >= 2 && ack) begin
            m_busy = 0;
            void'(sb.pop_front());
         end else if (m_age < 2) m_age++;
      end
   end
   task automatic tick(int k);
      repeat (k) @(posedge clk);
      #1;
   endtask
   // 0: r0 handshake, 1: r1 handshake, 2: not busy, 3: r1 response valid
   task automatic wait_until(int k, string nm);
      bit ok = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         case (k)
            0: ok = bus.r0_valid && bus.r0_ready;
            1: ok = bus.r1_valid && bus.r1_ready;
            2: ok = !bus.busy;
            default: ok = bus.r1_rsp_valid;
         endcase
         if (ok) break;
      end
      if (!ok) chk({"timeout_", nm}, 0, 1);
      @(posedge clk);
      #1;
   endtask
   task automatic req(bit n, bit v, logic [5:0] op, logic [31:0] a, logic [31:0] b);
      if (n) begin
         bus.r1_valid = v; bus.r1_op = op; bus.r1_in1 = a; bus.r1_in2 = b;
      end else begin
         bus.r0_valid = v; bus.r0_op = op; bus.r0_in1 = a; bus.r0_in2 = b;
      end
   endtask
   function automatic logic [5:0] rand_op();
      logic [4:0] lst [10] = '{5'b01000, 5'b11000, 5'b01001, 5'b01010, 5'b01011,
                               5'b01100, 5'b01101, 5'b11101, 5'b01110, 5'b01111};
      logic [4:0] lo = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : lst[$urandom_range(0, 9)];
      return {1'($urandom_range(0, 1)), lo};
   endfunction
   initial begin
      bus.r0_rsp_ready = 1;
      bus.r1_rsp_ready = 1;
      req(0, 1, 6'b001000, 5, 7);
      req(1, 1, 6'b011000, 10, 3);
      tick(2);
      rst = 0;
      grants.delete();
      gcyc.delete();
      wait_until(0, "first_r0");
      req(0, 1, 6'b001000, 1, 1);
      tick(9);
      if (grants.size() < 3) chk("rr_grant_count", grants.size(), 3);
      else begin
         chk("rr_grant0", grants[0], 0);
         chk("rr_grant1", grants[1], 1);
         chk("rr_grant2", grants[2], 0);
         chk("rr_spacing1", gcyc[1] - gcyc[0], 3);
         chk("rr_spacing2", gcyc[2] - gcyc[1], 3);
      end
      req(0, 0, 0, 0, 0);
      req(1, 0, 0, 0, 0);
      wait_until(2, "idle_b");
      bus.r1_rsp_ready = 0;
      req(1, 1, 6'b001001, 1, 4);
      wait_until(1, "sll_acc");
      req(1, 0, 0, 0, 0);
      req(0, 1, 6'b001110, 32'h0F0, 32'h00F);
      wait_until(3, "sll_rsp");
      tick(5);
      bus.r1_rsp_ready = 1;
      wait_until(0, "after_bp");
      req(0, 0, 0, 0, 0);
      wait_until(2, "idle_c");
      req(0, 1, 6'b000000, 3, 4);
      wait_until(0, "illegal_acc");
      req(0, 1, 6'b101000, 2, 2);
      wait_until(0, "legal_acc");
      req(0, 0, 0, 0, 0);
      wait_until(2, "idle_d");
      req(1, 1, 6'b001100, 32'hFF00, 32'h0FF0);
      wait_until(1, "xor_acc");
      rst = 1;
      req(0, 1, 6'b001000, 9, 9);
      tick(1);
      rst = 0;
      grants.delete();
      tick(4);
      if (grants.size() == 0) chk("post_rst_grant_count", 0, 1);
      else chk("post_rst_grant", grants[0], 0);
      for (int i = 0; i < 400; i++) begin
         req(0, $urandom_range(0, 9) < 7, rand_op(), $urandom, $urandom);
         req(1, $urandom_range(0, 9) < 7, rand_op(), $urandom, $urandom);
         bus.r0_rsp_ready = $urandom_range(0, 9) < 7;
         bus.r1_rsp_ready = $urandom_range(0, 9) < 7;
         rst = $urandom_range(0, 99) == 0;
         tick(1);
      end
      rst = 0;
      req(0, 0, 0, 0, 0);
      req(1, 0, 0, 0, 0);
      bus.r0_rsp_ready = 1;
      bus.r1_rsp_ready = 1;
      wait_until(2, "drain");
      tick(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
